// File: rtl/cmp_pkg.sv
// Shared encodings for the streaming magnitude comparator: one-hot result
// codes and the two FSM states.
package cmp_pkg;

   localparam logic [2:0] CMP_GT = 3'b100;
   localparam logic [2:0] CMP_EQ = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b001;

   typedef enum logic {
      S_ACCEPT = 1'b0,
      S_RESULT = 1'b1
   } state_t;

endpackage

// File: rtl/cmp_word.sv
// Combinational one-word compare producing a one-hot {gt,eq,lt} code.
// Signed interpretation is only ever requested for the most-significant word.
module cmp_word
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic [2:0]       res
);

   always_comb begin
      res = CMP_EQ;
      if (is_signed) begin
         if ($signed(a) > $signed(b))      res = CMP_GT;
         else if ($signed(a) < $signed(b)) res = CMP_LT;
      end else begin
         if (a > b)      res = CMP_GT;
         else if (a < b) res = CMP_LT;
      end
   end

endmodule

// File: rtl/cmp_stream.sv
// Sequential magnitude comparator: operands arrive MSW first, one word per
// beat; the first differing word decides the one-hot result.
module cmp_stream
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             signed_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dina,
   input  logic [WIDTH-1:0] dinb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both 1; valid never depends combinationally on ready on either side.

   localparam int            CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_mode;
   logic [2:0]    r_res;
   logic [2:0]    w_word_res;
   logic          w_beat;
   logic          w_first;
   logic          w_last;
   logic          w_is_signed;

   assign w_beat      = in_valid && (r_state == S_ACCEPT);
   assign w_first     = (r_cnt == '0);
   assign w_last      = (r_cnt == LAST);
   assign w_is_signed = w_first ? signed_mode : 1'b0;

   cmp_word #(.WIDTH(WIDTH)) u_word (
      .a         (dina),
      .b         (dinb),
      .is_signed (w_is_signed),
      .res       (w_word_res)
   );

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid && w_last) w_state_nxt = S_RESULT;
         end
         S_RESULT: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_ACCEPT;
         end
         default: w_state_nxt = S_ACCEPT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ACCEPT;
         r_cnt   <= '0;
         r_mode  <= 1'b0;
         r_res   <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         if (w_beat) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_first) r_mode <= signed_mode;
            // Once a word differs, lower words can no longer change the outcome.
            if (w_first || (r_res == CMP_EQ)) r_res <= w_word_res;
         end
      end
   end

   assign {gt, eq, lt} = r_res;
   assign o_dbg_state  = r_state;

   a_mode_stable_in_result : assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_state == S_RESULT) |=> $stable(r_mode)
   );

endmodule

// File: tb/tb_cmp_stream.sv
// Scoreboarded bench for cmp_stream: whole-operand reference compare, random
// gaps and backpressure, mid-operand reset, and a single-word build.
module tb_cmp_stream;

   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int OPW   = WIDTH * WORDS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (WORDS=4) ----------------
   logic             signed_mode = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] dina = '0;
   logic [WIDTH-1:0] dinb = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             gt, eq, lt;
   logic             dbg_state;

   cmp_stream #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dina        (dina),
      .dinb        (dinb),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .gt          (gt),
      .eq          (eq),
      .lt          (lt),
      .o_dbg_state (dbg_state)
   );

   // ---------------- DUT (WORDS=1) ----------------
   logic             s_sm = 1'b0;
   logic             s_in_valid = 1'b0;
   logic             s_in_ready;
   logic [WIDTH-1:0] s_dina = '0;
   logic [WIDTH-1:0] s_dinb = '0;
   logic             s_out_valid;
   logic             s_out_ready = 1'b1;
   logic             s_gt, s_eq, s_lt;
   logic             s_dbg_state;

   cmp_stream #(.WIDTH(WIDTH), .WORDS(1)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .signed_mode (s_sm),
      .in_valid    (s_in_valid),
      .in_ready    (s_in_ready),
      .dina        (s_dina),
      .dinb        (s_dinb),
      .out_valid   (s_out_valid),
      .out_ready   (s_out_ready),
      .gt          (s_gt),
      .eq          (s_eq),
      .lt          (s_lt),
      .o_dbg_state (s_dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [2:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: compare the complete operands in one go.
   function automatic logic [2:0] ref_cmp(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                          input logic sm);
      if (sm) begin
         if ($signed(a) > $signed(b)) return 3'b100;
         if ($signed(a) < $signed(b)) return 3'b001;
         return 3'b010;
      end
      if (a > b) return 3'b100;
      if (a < b) return 3'b001;
      return 3'b010;
   endfunction

   // ---------------- out_ready driver ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_result", 32'(out_valid), 32'd0);
         end else begin
            check_eq("result_flags", 32'({gt, eq, lt}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present one word and hold it until accepted (bounded).
   task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
      bit done = 0;
      in_valid    = 1'b1;
      dina        = a;
      dinb        = b;
      signed_mode = sm;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) check_eq("beat_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      dina     = WIDTH'($urandom);
      dinb     = WIDTH'($urandom);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full operand; later-beat signed_mode is randomised since it must be ignored.
   task automatic send_operand(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                               input logic sm, input int max_gap);
      for (int i = 0; i < WORDS; i++) begin
         idle($urandom_range(0, max_gap));
         send_word(a[OPW-1-i*WIDTH -: WIDTH], b[OPW-1-i*WIDTH -: WIDTH],
                   (i == 0) ? sm : 1'($urandom_range(0, 1)));
      end
      exp_q.push_back(ref_cmp(a, b, sm));
      check_eq("latency_out_valid", 32'(out_valid), 32'd1);
      check_eq("latency_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) begin
         @(posedge clk);
         #1;
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [OPW-1:0] a, b;
      logic [2:0]     e;

      #2;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_flags", 32'({gt, eq, lt}), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single-word build: unsigned then signed.
      for (int m = 0; m < 2; m++) begin
         s_in_valid = 1'b1;
         s_dina     = 8'hFF;
         s_dinb     = 8'h01;
         s_sm       = 1'(m);
         check_eq("w1_in_ready", 32'(s_in_ready), 32'd1);
         @(posedge clk);
         #1;
         s_in_valid = 1'b0;
         check_eq("w1_out_valid", 32'(s_out_valid), 32'd1);
         check_eq("w1_flags", 32'({s_gt, s_eq, s_lt}), (m == 0) ? 32'h4 : 32'h1);
         @(posedge clk);
         #1;
         check_eq("w1_out_valid_drop", 32'(s_out_valid), 32'd0);
      end

      // Directed operands, back to back.
      rdy_mode = 0;
      send_operand(32'h12345678, 32'h12345678, 1'b0, 0);
      check_eq("dbg_state_result", 32'(dbg_state), 32'd1);
      send_operand(32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
      send_operand(32'h80000000, 32'h7FFFFFFF, 1'b1, 0);
      send_operand(32'hAABBCC01, 32'hAABBCC02, 1'b0, 0);
      send_operand(32'h05000000, 32'h04FFFFFF, 1'b0, 0);
      send_operand(32'hAABBCC01, 32'hAABBCC02, 1'b0, 3);

      // Backpressure: result held while junk words are offered.
      wait_drain();
      rdy_mode = 1;
      a = 32'h00FF0010;
      b = 32'h00FF0011;
      e = ref_cmp(a, b, 1'b0);
      send_operand(a, b, 1'b0, 2);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         dina     = WIDTH'($urandom);
         dinb     = WIDTH'($urandom);
         @(negedge clk);
         check_eq("bp_out_valid", 32'(out_valid), 32'd1);
         check_eq("bp_flags", 32'({gt, eq, lt}), 32'(e));
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      send_operand(32'h11223344, 32'h11223343, 1'b1, 1);

      // Reset in the middle of an operand.
      wait_drain();
      send_word(8'h7F, 8'h00, 1'b1);
      send_word(8'h00, 8'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_flags", 32'({gt, eq, lt}), 32'd0);
      check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_operand(32'h01000000, 32'h00FFFFFF, 1'b0, 0);

      // Randomised traffic with random gaps and random out_ready.
      rdy_mode = 2;
      for (int n = 0; n < 60; n++) begin
         a = OPW'($urandom);
         case ($urandom_range(0, 3))
            0: b = OPW'($urandom);
            1: b = a;
            2: begin
               int k;
               k = $urandom_range(0, WORDS - 1);
               b = a;
               b[OPW-1-k*WIDTH -: WIDTH] = WIDTH'($urandom);
            end
            default: b = a ^ (OPW'(1) << $urandom_range(0, OPW - 1));
         endcase
         send_operand(a, b, 1'($urandom_range(0, 1)), 3);
      end

      rdy_mode = 0;
      wait_drain();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, pending %0d", exp_q.size());
      $fatal(1, "watchdog expired");
   end

endmodule
